// File: rtl/r88_regfile_param.sv
// r88_regfile_param: Rocket88 register block with configurable counts.
// Holds the 8-bit general registers, the 16-bit pointer registers (PC and
// SP among them) and a packed status byte, and feeds the data bus, the ALU
// operand inputs and the address unit. All outputs are registered.
module r88_regfile_param #(
    parameter int          NUM_GPR = 3,
    parameter int          NUM_PTR = 4,
    parameter int          PC_IDX  = 2,
    parameter int          SP_IDX  = 3,
    parameter logic [15:0] PC_RST  = 16'h0000,
    parameter logic [15:0] SP_RST  = 16'hFFF9,
    parameter int          SEL_W   = 4
) (
    input  logic             sysClock,
    input  logic             sysReset,
    input  logic [7:0]       busIn,
    input  logic [7:0]       highIn,
    output logic [7:0]       busOut,
    output logic             busOutEn,
    input  logic [SEL_W-1:0] regSel,
    input  logic             regWrite,
    input  logic             regRead,
    input  logic             wide16,
    input  logic [2:0]       rightSel,
    input  logic [2:0]       leftSel,
    input  logic             leftWide,
    input  logic [2:0]       addrSel,
    input  logic [1:0]       ptrOp,
    input  logic [2:0]       ptrSel,
    input  logic             incPC,
    input  logic             carryIn,
    input  logic             decMode,
    input  logic             breakFlag,
    input  logic             irqEn,
    output logic [7:0]       regRight,
    output logic [15:0]      regLeft,
    output logic [15:0]      regAddr,
    output logic             signFlag,
    output logic             zeroFlag,
    output logic             ptrWrap
);

    localparam int STATUS_IDX = NUM_GPR + 2 * NUM_PTR;

    localparam logic [1:0] OP_INC = 2'd1;
    localparam logic [1:0] OP_DEC = 2'd2;

    logic [7:0]  gpr_q   [NUM_GPR];
    logic [15:0] ptr_q   [NUM_PTR];
    logic [15:0] ptr_nxt [NUM_PTR];

    logic [NUM_GPR-1:0] gpr_we;
    logic [NUM_PTR-1:0] ptr_lo_we;
    logic [NUM_PTR-1:0] ptr_hi_we;
    logic [NUM_PTR-1:0] wrap_vec;

    logic [7:0]  rd_data;
    logic [7:0]  status_byte;
    logic [7:0]  right_nxt;
    logic [15:0] left_nxt;
    logic [15:0] addr_nxt;

    assign status_byte = {signFlag, zeroFlag, carryIn, irqEn, decMode, breakFlag, 2'b00};

    // Decode the write strobe into per-register byte enables.
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gpr_we    = '0;
        ptr_lo_we = '0;
        ptr_hi_we = '0;
        if (regWrite) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (regSel == SEL_W'(i)) gpr_we[i] = 1'b1;
            end
            for (int p = 0; p < NUM_PTR; p++) begin
                if (regSel == SEL_W'(NUM_GPR + 2 * p)) begin
                    ptr_lo_we[p] = 1'b1;
                    // A wide write through the low-byte index also loads the high byte.
                    if (wide16) ptr_hi_we[p] = 1'b1;
                end
                if (regSel == SEL_W'(NUM_GPR + 2 * p + 1)) ptr_hi_we[p] = 1'b1;
            end
        end
    end

    // Next pointer values: write beats ptrOp, ptrOp beats incPC.
    always_comb begin
        for (int p = 0; p < NUM_PTR; p++) begin
            ptr_nxt[p]  = ptr_q[p];
            wrap_vec[p] = 1'b0;
            if (ptr_lo_we[p] || ptr_hi_we[p]) begin
                if (ptr_lo_we[p]) ptr_nxt[p][7:0]  = busIn;
                if (ptr_hi_we[p]) ptr_nxt[p][15:8] = ptr_lo_we[p] ? highIn : busIn;
            end else if (ptrSel == 3'(p) && ptrOp == OP_INC) begin
                ptr_nxt[p]  = ptr_q[p] + 16'd1;
                wrap_vec[p] = (ptr_q[p] == 16'hFFFF);
            end else if (ptrSel == 3'(p) && ptrOp == OP_DEC) begin
                ptr_nxt[p]  = ptr_q[p] - 16'd1;
                wrap_vec[p] = (ptr_q[p] == 16'h0000);
            end else if (p == PC_IDX && incPC) begin
                ptr_nxt[p]  = ptr_q[p] + 16'd1;
                wrap_vec[p] = (ptr_q[p] == 16'hFFFF);
            end
        end
    end

    // Bus read mux over the index map; unmapped indices read as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (regSel == SEL_W'(i)) rd_data = gpr_q[i];
        end
        for (int p = 0; p < NUM_PTR; p++) begin
            if (regSel == SEL_W'(NUM_GPR + 2 * p))     rd_data = ptr_q[p][7:0];
            if (regSel == SEL_W'(NUM_GPR + 2 * p + 1)) rd_data = ptr_q[p][15:8];
        end
        if (regSel == SEL_W'(STATUS_IDX)) rd_data = status_byte;
    end

    // Operand and address muxes; out-of-range selects give zero.
    always_comb begin
        right_nxt = 8'h00;
        left_nxt  = 16'h0000;
        addr_nxt  = 16'h0000;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (rightSel == 3'(i + 1))        right_nxt = gpr_q[i];
            if (!leftWide && leftSel == 3'(i)) left_nxt = {8'h00, gpr_q[i]};
            if (addrSel == 3'd0 && i == 1)    addr_nxt[15:8] = gpr_q[i];
            if (addrSel == 3'd0 && i == 2)    addr_nxt[7:0]  = gpr_q[i];
        end
        for (int p = 0; p < NUM_PTR; p++) begin
            if (leftWide && leftSel == 3'(p)) left_nxt = ptr_q[p];
            if (addrSel == 3'(p + 1))         addr_nxt = ptr_q[p];
        end
    end

    // Register state update; reset wins over every pending operation.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            // NOTE: the register arrays are reset explicitly because software relies on their power-up values.
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= (i == 0) ? 8'h00 : 8'hFF;
            for (int p = 0; p < NUM_PTR; p++) begin
                ptr_q[p] <= (p == PC_IDX) ? PC_RST : ((p == SP_IDX) ? SP_RST : 16'h0000);
            end
            busOut   <= 8'h00;
            busOutEn <= 1'b0;
            regRight <= 8'h00;
            regLeft  <= 16'h0000;
            regAddr  <= 16'h0000;
            signFlag <= 1'b0;
            zeroFlag <= 1'b0;
            ptrWrap  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gpr_we[i]) gpr_q[i] <= busIn;
            end
            for (int p = 0; p < NUM_PTR; p++) ptr_q[p] <= ptr_nxt[p];
            // Read data is taken from pre-write state, so a same-cycle write is not visible.
            if (regRead) busOut <= rd_data;
            busOutEn <= regRead;
            regRight <= right_nxt;
            regLeft  <= left_nxt;
            regAddr  <= addr_nxt;
            if (|gpr_we) begin
                signFlag <= busIn[7];
                zeroFlag <= (busIn == 8'h00);
            end
            ptrWrap <= |wrap_vec;
        end
    end

endmodule

// File: tb/tb_r88_regfile_param.sv
// Directed testbench for r88_regfile_param with hand-computed expectations.
module tb_r88_regfile_param;

    logic        sysClock = 1'b0;
    logic        sysReset;
    logic [7:0]  busIn, highIn, busOut;
    logic        busOutEn;
    logic [3:0]  regSel;
    logic        regWrite, regRead, wide16;
    logic [2:0]  rightSel, leftSel, addrSel, ptrSel;
    logic        leftWide, incPC;
    logic [1:0]  ptrOp;
    logic        carryIn, decMode, breakFlag, irqEn;
    logic [7:0]  regRight;
    logic [15:0] regLeft, regAddr;
    logic        signFlag, zeroFlag, ptrWrap;

    int checks = 0;
    int errors = 0;

    r88_regfile_param dut (
        .sysClock (sysClock),  .sysReset (sysReset),
        .busIn    (busIn),     .highIn   (highIn),
        .busOut   (busOut),    .busOutEn (busOutEn),
        .regSel   (regSel),    .regWrite (regWrite),
        .regRead  (regRead),   .wide16   (wide16),
        .rightSel (rightSel),  .leftSel  (leftSel),
        .leftWide (leftWide),  .addrSel  (addrSel),
        .ptrOp    (ptrOp),     .ptrSel   (ptrSel),
        .incPC    (incPC),     .carryIn  (carryIn),
        .decMode  (decMode),   .breakFlag(breakFlag),
        .irqEn    (irqEn),     .regRight (regRight),
        .regLeft  (regLeft),   .regAddr  (regAddr),
        .signFlag (signFlag),  .zeroFlag (zeroFlag),
        .ptrWrap  (ptrWrap)
    );

    always #5 sysClock = ~sysClock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge sysClock);
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [7:0] d, input logic w16, input logic [7:0] hi);
        regSel = sel; busIn = d; wide16 = w16; highIn = hi; regWrite = 1'b1;
        step();
        regWrite = 1'b0; wide16 = 1'b0;
    endtask

    initial begin
        sysReset = 1'b1; busIn = '0; highIn = '0; regSel = '0; regWrite = 0; regRead = 0;
        wide16 = 0; rightSel = '0; leftSel = '0; leftWide = 0; addrSel = '0; ptrOp = '0;
        ptrSel = '0; incPC = 0; carryIn = 0; decMode = 0; breakFlag = 0; irqEn = 0;
        step(); step();
        sysReset = 1'b0;
        check("rst_busOut",   {8'h00, busOut}, 16'h0000);
        check("rst_busOutEn", {15'd0, busOutEn}, 16'h0000);
        check("rst_regAddr",  regAddr, 16'h0000);
        check("rst_flags",    {14'd0, signFlag, zeroFlag}, 16'h0000);

        // SP reads after reset
        regRead = 1'b1; regSel = 4'd9;
        step();
        check("sp_lo", {7'd0, busOutEn, busOut}, {8'h01, 8'hF9});
        regSel = 4'd10;
        step();
        check("sp_hi", {7'd0, busOutEn, busOut}, {8'h01, 8'hFF});
        regRead = 1'b0;
        step();
        check("read_idle", {7'd0, busOutEn, busOut}, {8'h00, 8'hFF});
        check("addr_rst_gpr", regAddr, 16'hFFFF);

        // GPR writes and flags
        wr(4'd1, 8'h80, 1'b0, 8'h00);
        check("flags_neg", {14'd0, signFlag, zeroFlag}, 16'h0002);
        wr(4'd2, 8'h00, 1'b0, 8'h00);
        check("flags_zero", {14'd0, signFlag, zeroFlag}, 16'h0001);
        rightSel = 3'd2;
        step();
        check("addr_gpr12", regAddr, 16'h8000);
        check("right_gpr1", {8'h00, regRight}, 16'h0080);

        // Status byte: {s=0,z=1,c=1,irq=0,dec=1,brk=0,0,0} = 8'h68; unmapped index reads 0
        carryIn = 1'b1; decMode = 1'b1; regRead = 1'b1; regSel = 4'd11;
        step();
        check("status", {8'h00, busOut}, 16'h0068);
        regSel = 4'd12;
        step();
        check("unmapped_rd", {8'h00, busOut}, 16'h0000);
        regRead = 1'b0; carryIn = 1'b0; decMode = 1'b0;

        // Wide pointer write and left operand
        wr(4'd3, 8'h34, 1'b1, 8'h12);
        leftWide = 1'b1; leftSel = 3'd0;
        step();
        check("left_p0", regLeft, 16'h1234);

        // SP decrement wrap
        wr(4'd9, 8'h00, 1'b1, 8'h00);
        ptrOp = 2'd2; ptrSel = 3'd3;
        step();
        ptrOp = 2'd0;
        check("sp_dec_wrap", {15'd0, ptrWrap}, 16'h0001);
        addrSel = 3'd4;
        step();
        check("wrap_pulse_end", {15'd0, ptrWrap}, 16'h0000);
        check("sp_after_dec", regAddr, 16'hFFFF);

        // Same with overriding write
        wr(4'd9, 8'h00, 1'b1, 8'h00);
        ptrOp = 2'd2; ptrSel = 3'd3;
        wr(4'd9, 8'h10, 1'b0, 8'h00);
        ptrOp = 2'd0;
        check("sp_wr_no_wrap", {15'd0, ptrWrap}, 16'h0000);
        step();
        check("sp_written", regAddr, 16'h0010);

        // PC write beats incPC, then incPC alone
        addrSel = 3'd3;
        wr(4'd7, 8'hFF, 1'b1, 8'h00);
        incPC = 1'b1;
        wr(4'd8, 8'h40, 1'b0, 8'h00);
        step();
        incPC = 1'b0;
        check("pc_write_wins", regAddr, 16'h40FF);
        step();
        check("pc_inc", regAddr, 16'h4100);
        check("pc_no_wrap", {15'd0, ptrWrap}, 16'h0000);

        // incPC wrap from FFFF
        wr(4'd7, 8'hFF, 1'b1, 8'hFF);
        incPC = 1'b1;
        step();
        incPC = 1'b0;
        check("pc_inc_wrap", {15'd0, ptrWrap}, 16'h0001);
        step();
        check("pc_wrapped", regAddr, 16'h0000);

        // decrement with incPC on PC=0 -> FFFF, wraps
        ptrOp = 2'd2; ptrSel = 3'd2; incPC = 1'b1;
        step();
        ptrOp = 2'd0; incPC = 1'b0;
        check("pc_dec_inc_wrap", {15'd0, ptrWrap}, 16'h0001);
        step();
        check("pc_dec_inc", regAddr, 16'hFFFF);

        // Read-before-write on GPR0
        regRead = 1'b1;
        wr(4'd0, 8'h5A, 1'b0, 8'h00);
        check("rbw_old", {8'h00, busOut}, 16'h0000);
        step();
        check("rbw_new", {8'h00, busOut}, 16'h005A);
        regRead = 1'b0;

        // Reset together with a write discards the write
        sysReset = 1'b1;
        wr(4'd0, 8'h77, 1'b0, 8'h00);
        sysReset = 1'b0;
        check("rst_outputs", {7'd0, busOutEn, busOut}, 16'h0000);
        regSel = 4'd0; regRead = 1'b1;
        step();
        regRead = 1'b0;
        check("rst_gpr0", {7'd0, busOutEn, busOut}, 16'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
